// File: rtl/shift_reg_out_if.sv
// Host/SPI-side signal bundle for the parallel-in, serial-out byte transmitter.
// master drives strobe, data and bit clock; slave (the transmitter) returns serial data and busy.
interface shift_reg_out_if #(
    parameter int unsigned WIDTH = 8
);
    logic             set_enable;
    logic [WIDTH-1:0] data_in;
    logic             serial_clk;
    logic             serial_out;
    logic             busy;

    modport master (
        output set_enable,
        output data_in,
        output serial_clk,
        input  serial_out,
        input  busy
    );

    modport slave (
        input  set_enable,
        input  data_in,
        input  serial_clk,
        output serial_out,
        output busy
    );
endinterface

// File: rtl/shift_reg_out.sv
// Parallel-in, serial-out SPI byte transmitter, MSB first, paced by a sampled serial_clk.
// Everything runs on set_clk; serial_clk and set_enable are synchronised and edge-detected.
module shift_reg_out #(
    parameter int unsigned WIDTH      = 8,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic           set_clk,
    input  logic           reset,
    shift_reg_out_if.slave bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             busy_q,  busy_d;
    logic             sout_q,  sout_d;

    // [0],[1] synchronise; [2] holds the previous synchronised value for edge detection
    logic [2:0] sclk_sync_q;
    logic [2:0] en_sync_q;

    logic sclk_fall_c;
    logic en_fall_c;

    always_ff @(posedge set_clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= 3'b000;
            en_sync_q   <= 3'b111;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], bus.serial_clk};
            en_sync_q   <= {en_sync_q[1:0], bus.set_enable};
        end
    end

    assign sclk_fall_c = sclk_sync_q[2] & ~sclk_sync_q[1];
    assign en_fall_c   = en_sync_q[2] & ~en_sync_q[1];

    always_ff @(posedge set_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            sout_q  <= IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            sout_q  <= sout_d;
        end
    end

    // A load in IDLE takes priority over a coincident serial_clk edge, which is simply dropped
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        sout_d  = sout_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                sout_d = IDLE_LEVEL;
                if (en_fall_c) begin
                    state_d = ST_SHIFT;
                    shreg_d = bus.data_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    sout_d  = bus.data_in[WIDTH-1];
                end
            end
            ST_SHIFT: begin
                busy_d = 1'b1;
                if (sclk_fall_c) begin
                    if (cnt_q == LAST_BIT) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        sout_d  = IDLE_LEVEL;
                    end else begin
                        shreg_d = shreg_q << 1;
                        sout_d  = shreg_q[WIDTH-2];
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                sout_d  = IDLE_LEVEL;
            end
        endcase
    end

    assign bus.serial_out = sout_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_shift_reg_out.sv
// Bench for shift_reg_out: acts as SPI master/receiver, sampling serial_out on serial_clk rising edges.
module tb_shift_reg_out;

    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst;

    shift_reg_out_if #(.WIDTH(WIDTH)) bus ();

    shift_reg_out #(
        .WIDTH      (WIDTH),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .set_clk (clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int unsigned total      = 0;
    int unsigned passed     = 0;
    int unsigned idle_viol  = 0;
    int unsigned busy_rises = 0;
    logic        busy_prev  = 1'b0;
    logic [2:0]  ph         = 3'd0;
    logic        rx_q[$];

    typedef struct {
        logic [7:0]  data;
        int unsigned k;
        int unsigned hold;
        logic [7:0]  exp;
        string       name;
    } vec_t;

    // serial_clk period = 8 set_clk cycles, changing 2 ns after the set_clk rising edge; falls when ph wraps to 0
    initial begin
        bus.serial_clk = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            ph = ph + 3'd1;
            bus.serial_clk = ph[2];
        end
    end

    always @(posedge bus.serial_clk) begin
        if (bus.busy === 1'b1) rx_q.push_back(bus.serial_out);
    end

    always @(negedge clk) begin
        if (bus.busy === 1'b1 && busy_prev !== 1'b1) busy_rises++;
        busy_prev = bus.busy;
        if (bus.busy !== 1'b1 && bus.serial_out !== 1'b1) idle_viol++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    // Land just after a serial_clk falling edge, then k further cycles
    task automatic align(input int unsigned k);
        tick(1);
        for (int i = 0; i < 16 && ph != 3'd0; i++) tick(1);
        tick(k);
    endtask

    task automatic wait_busy_low(input string name);
        int unsigned n = 0;
        while (bus.busy === 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        check({name, "_busy_low"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_rx(input int unsigned cnt);
        int unsigned n = 0;
        while (rx_q.size() < cnt && n < 400) begin
            tick(1);
            n++;
        end
        if (n >= 400) check("rx_timeout", 32'(rx_q.size()), 32'(cnt));
    endtask

    // Reference: a transfer delivers the byte's bits MSB first, one per serial_clk period
    task automatic check_rx(input string name, input logic [7:0] byte_v);
        logic [31:0] got = '0;
        logic [31:0] want = '0;
        for (int i = 0; i < int'(WIDTH); i++) want = {want[30:0], 1'((byte_v >> (WIDTH - 1 - i)) & 8'd1)};
        foreach (rx_q[i]) got = {got[30:0], rx_q[i]};
        check({name, "_nbits"}, 32'(rx_q.size()), 32'(WIDTH));
        check({name, "_bits"}, got, want);
    endtask

    task automatic run_xfer(input logic [7:0] d, input int unsigned k, input int unsigned hold,
                            input logic [7:0] exp, input string name);
        int unsigned r0;
        bus.data_in = d;
        align(k);
        rx_q.delete();
        r0 = busy_rises;
        bus.set_enable = 1'b0;
        tick(3);
        check({name, "_busy_up"}, 32'(bus.busy), 32'd1);
        bus.data_in = 8'($urandom);
        if (hold > 3) tick(hold - 3);
        bus.set_enable = 1'b1;
        wait_busy_low(name);
        tick(20);
        check_rx(name, exp);
        check({name, "_one_xfer"}, busy_rises - r0, 32'd1);
    endtask

    vec_t vecs[4];

    initial begin
        int unsigned r0;
        logic [7:0]  d;

        vecs[0] = '{8'hF1, 0, 80,   8'hF1, "F1"};
        vecs[1] = '{8'hA5, 1, 40,   8'hA5, "A5"};
        vecs[2] = '{8'h3C, 0, 1000, 8'h3C, "3C_held"};
        vecs[3] = '{8'h00, 1, 4,    8'h00, "00"};

        rst = 1'b1;
        bus.set_enable = 1'b1;
        bus.data_in = '0;
        #1100;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_sout", 32'(bus.serial_out), 32'd1);
        rst = 1'b0;
        tick(100);
        check("idle_no_xfer", busy_rises, 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);

        foreach (vecs[i]) run_xfer(vecs[i].data, vecs[i].k, vecs[i].hold, vecs[i].exp, vecs[i].name);

        // Strobe pulsed mid-transfer is ignored and not queued
        bus.data_in = 8'hF1;
        align(0);
        rx_q.delete();
        r0 = busy_rises;
        bus.set_enable = 1'b0;
        tick(4);
        bus.set_enable = 1'b1;
        wait_rx(2);
        bus.set_enable = 1'b0;
        tick(3);
        bus.set_enable = 1'b1;
        wait_busy_low("midpulse");
        tick(40);
        check_rx("midpulse", 8'hF1);
        check("midpulse_one_xfer", busy_rises - r0, 32'd1);

        // Strobe coinciding with the last bit's falling edge is dropped
        bus.data_in = 8'h5A;
        align(0);
        rx_q.delete();
        r0 = busy_rises;
        bus.set_enable = 1'b0;
        tick(4);
        bus.set_enable = 1'b1;
        wait_rx(WIDTH);
        align(0);
        bus.set_enable = 1'b0;
        tick(40);
        check("lastedge_busy", 32'(bus.busy), 32'd0);
        check("lastedge_one_xfer", busy_rises - r0, 32'd1);
        check_rx("lastedge", 8'h5A);
        bus.set_enable = 1'b1;
        tick(5);

        // Asynchronous reset after the third bit, then a clean transfer
        bus.data_in = 8'hF1;
        align(0);
        rx_q.delete();
        bus.set_enable = 1'b0;
        tick(4);
        bus.set_enable = 1'b1;
        wait_rx(3);
        rst = 1'b1;
        #1;
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_sout", 32'(bus.serial_out), 32'd1);
        tick(3);
        rst = 1'b0;
        tick(20);
        check("postreset_busy", 32'(bus.busy), 32'd0);
        run_xfer(8'h81, 0, 6, 8'h81, "81");

        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            run_xfer(d, $urandom_range(0, 1), $urandom_range(2, 12), d, $sformatf("rnd%0d", i));
        end

        check("idle_level", idle_viol, 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shift_reg_out.md
Name: shift_reg_out

Overview:
- Parallel-in, serial-out byte transmitter for the SPI output path.
- A host writes a byte with an active-low strobe (set_enable). The block shifts the byte out MSB first on serial_out, paced by an externally supplied serial bit clock (serial_clk).
- busy is high while a transfer is in progress.
- All logic runs on the single system clock set_clk. serial_clk is treated as a sampled data input, not as a clock.

Parameters:
- WIDTH, 8, number of bits per transfer.
- IDLE_LEVEL, 1'b1, serial_out level when no transfer is active.

Ports:
- set_clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- set_enable  input  1  active-low load strobe; a high-to-low transition requests a load.
- data_in  input  WIDTH  parallel byte, captured at load.
- serial_clk  input  1  serial bit clock from the SPI side; synchronised into the set_clk domain.
- serial_out  output  1  serial data, MSB first; changes after serial_clk falling edges (SPI mode 0 timing).
- busy  output  1  high from load until the last bit's serial_clk period completes.

Interface decided: one clock (set_clk); reset is asynchronous and active-high.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - busy=0, serial_out=IDLE_LEVEL.
  - Shift register=0, bit counter=0.
  - Synchroniser and edge-detect flops are set to set_enable=1 and serial_clk=0.
- Synchronisation:
  - serial_clk passes through a 2-flop synchroniser, then a third flop for edge detection.
  - set_enable passes through a 2-flop synchroniser plus a previous-value flop.
  - Input-to-detection latency is 2 set_clk cycles for both signals.
- Load condition:
  - Requires a detected set_enable falling edge (synced prev=1, cur=0) while busy=0.
  - On the next set_clk edge: shift register←data_in, counter←0, busy←1, serial_out←data_in[WIDTH-1].
- Strobe rules:
  - Holding set_enable low does not retrigger a load; a new high-to-low transition is required.
  - A set_enable falling edge while busy=1 is ignored and not queued.
- State machine:
  - IDLE: busy=0, serial_out=IDLE_LEVEL. Goes to SHIFT on load.
  - SHIFT: busy=1. On each detected serial_clk falling edge:
    - if counter<WIDTH-1: shift left, serial_out←next bit, counter+1;
    - if counter==WIDTH-1: go to IDLE, busy←0, serial_out←IDLE_LEVEL.
  - Rising edges of serial_clk cause no state change. The receiver samples on them.
- Transfer length:
  - Each bit is held for exactly one full serial_clk period, falling edge to falling edge.
  - The first bit is valid from load until the first detected falling edge.
  - busy duration ≈ WIDTH serial_clk periods plus synchroniser latency.
- Simultaneous events:
  - A load and a serial_clk falling edge in the same cycle while IDLE: the load wins and the edge is ignored.
  - The last-bit falling edge and a set_enable falling edge in the same cycle: the load is ignored because busy is still 1 in that cycle.
- Timing requirement on the driving side: each serial_clk phase must be at least 1 set_clk period. The nominal configuration is serial_clk = set_clk/2.
- Outputs are registered, with no combinational path from inputs.
- data_in is only sampled at load and may change freely during SHIFT.

Test Plan:
- Reset held 1100 ns, then released → busy=0, serial_out=1 throughout; no activity with set_enable=1.
- data_in=8'hF1, set_enable low for 800 ns → busy rises within 3 set_clk cycles. serial_out sampled on successive serial_clk rising edges reads 1,1,1,1,0,0,0,1. busy falls after the 8th bit; serial_out returns to 1.
- After idle, data_in=8'hA5, set_enable low for 400 ns → bits 1,0,1,0,0,1,0,1, then busy=0.
- set_enable pulsed low again mid-transfer (during 0xF1) → ignored; the transmitted sequence is unchanged and no second transfer follows.
- set_enable held low for 10 µs with data_in=8'h3C → exactly one transfer (0,0,1,1,1,1,0,0); no retrigger until set_enable returns high and falls again.
- reset asserted after the 3rd bit of 8'hF1 → busy=0 and serial_out=1 immediately (asynchronous). A subsequent load of 8'h81 transmits a clean 1,0,0,0,0,0,0,1.
